// File: rtl/sm_cfg_pkg.sv
// sm_cfg_pkg: shared constants, side codes and loader FSM states (READBACK state only with SM_CFG_READBACK_EN)
package sm_cfg_pkg;
    localparam int N_TB   = 5;
    localparam int N_LR   = 4;
    localparam int WORD_W = 6;
    localparam int NSLOT  = 2 * N_TB + 2 * N_LR;
    localparam int NBITS  = NSLOT * WORD_W;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        SIDE_NONE   = 3'd0,
        SIDE_TOP    = 3'd1,
        SIDE_RIGHT  = 3'd2,
        SIDE_BOTTOM = 3'd3,
        SIDE_LEFT   = 3'd4
    } side_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT
`ifdef SM_CFG_READBACK_EN
        , READBACK
`endif
    } state_e;
endpackage

// File: rtl/sm_cfg_deser.sv
// sm_cfg_deser: MSB-first 6-bit deserialiser; word_valid fires combinationally on the bit that completes a word
module sm_cfg_deser
    import sm_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              bit_en,
    input  logic              bit_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    logic [WORD_W-2:0] sh_q, sh_d;
    logic [2:0]        cnt_q, cnt_d;

    // shift accepted bits in and count position within the current word
    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        word       = {sh_q, bit_in};
        word_valid = bit_en && (cnt_q == 3'(WORD_W - 1));
        if (clr) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (bit_en) begin
            sh_d  = word[WORD_W-2:0];
            cnt_d = word_valid ? 3'd0 : cnt_q + 3'd1;
        end
    end

    // deserialiser state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sm_cfg_loader.sv
// sm_cfg_loader: sync hunt, load 18 route words + checksum into a shadow store, commit atomically on match.
// Optional bus readback port and state when SM_CFG_READBACK_EN is defined.
module sm_cfg_loader
    import sm_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
`ifdef SM_CFG_READBACK_EN
    input  logic             rb_req,
    output logic             rb_dout,
    output logic             rb_valid,
`endif
    input  logic             cfg_en,
    input  logic             cfg_din,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [NBITS-1:0] cfg_bus,
    output logic             cfg_done,
    output logic             cfg_err
);
    state_e            state_q, state_d;
    logic [7:0]        win_q, win_d;
    logic [4:0]        slot_q, slot_d;
    logic [WORD_W-1:0] xor_q, xor_d;
    logic              match_q, match_d;
    logic [NBITS-1:0]  shadow_q, shadow_d;
    logic [NBITS-1:0]  bus_q, bus_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              in_frame, accept, word_valid;
    logic [WORD_W-1:0] word;
`ifdef SM_CFG_READBACK_EN
    logic [2:0]        rb_bit_q, rb_bit_d;
    logic              rb_dout_q, rb_dout_d;
    logic              rb_valid_q, rb_valid_d;
    logic [6:0]        rb_idx;

    assign rb_idx   = 7'(slot_q) * 7'd6 + 7'd5 - 7'(rb_bit_q);
    assign rb_dout  = rb_dout_q;
    assign rb_valid = rb_valid_q;
`endif

    assign in_frame  = (state_q == LOAD) || (state_q == CHECK);
    assign cfg_ready = cfg_en && ((state_q == IDLE) || in_frame);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_bus   = bus_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

    // the deserialiser idles cleared outside a frame so every frame starts word-aligned
    sm_cfg_deser u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (!in_frame),
        .bit_en     (accept && in_frame),
        .bit_in     (cfg_din),
        .word_valid (word_valid),
        .word       (word)
    );

    // next-state logic: sync hunt, word capture, checksum compare and commit
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        slot_d   = slot_q;
        xor_d    = xor_q;
        match_d  = match_q;
        shadow_d = shadow_q;
        bus_d    = bus_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef SM_CFG_READBACK_EN
        rb_bit_d   = rb_bit_q;
        rb_dout_d  = 1'b0;
        rb_valid_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept)
                    win_d = {win_q[6:0], cfg_din};
`ifdef SM_CFG_READBACK_EN
                if (rb_req) begin
                    state_d  = READBACK;
                    slot_d   = '0;
                    rb_bit_d = '0;
                end else if (accept && (win_d == SYNC)) begin
`else
                if (accept && (win_d == SYNC)) begin
`endif
                    state_d = LOAD;
                    win_d   = '0;
                    slot_d  = '0;
                    xor_d   = '0;
                end
            end
            LOAD: begin
                if (!cfg_en) begin
                    state_d = IDLE;
                end else if (word_valid) begin
                    shadow_d[7'(slot_q) * 7'd6 +: WORD_W] = word;
                    xor_d  = xor_q ^ word;
                    slot_d = slot_q + 5'd1;
                    if (slot_q == 5'(NSLOT - 1))
                        state_d = CHECK;
                end
            end
            CHECK: begin
                if (!cfg_en) begin
                    state_d = IDLE;
                end else if (word_valid) begin
                    match_d = (word == xor_q);
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bus_d   = match_q ? shadow_q : bus_q;
                done_d  = match_q;
                err_d   = !match_q;
                state_d = IDLE;
            end
`ifdef SM_CFG_READBACK_EN
            READBACK: begin
                rb_valid_d = 1'b1;
                rb_dout_d  = bus_q[rb_idx];
                rb_bit_d   = (rb_bit_q == 3'd5) ? 3'd0 : rb_bit_q + 3'd1;
                if (rb_bit_q == 3'd5) begin
                    slot_d = slot_q + 5'd1;
                    if (slot_q == 5'(NSLOT - 1))
                        state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state, shadow store and active bus registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            slot_q   <= '0;
            xor_q    <= '0;
            match_q  <= 1'b0;
            shadow_q <= '0;
            bus_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            slot_q   <= slot_d;
            xor_q    <= xor_d;
            match_q  <= match_d;
            shadow_q <= shadow_d;
            bus_q    <= bus_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef SM_CFG_READBACK_EN
    // readback output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_bit_q   <= '0;
            rb_dout_q  <= 1'b0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_bit_q   <= rb_bit_d;
            rb_dout_q  <= rb_dout_d;
            rb_valid_q <= rb_valid_d;
        end
    end
`endif
endmodule
